muldiv_sequencer: RTL and testbench
===================================

# muldiv_sequencer

Multi-cycle sequencer for the RV32M operations, MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU, sitting in the EX stage beside the single-cycle ALU. It accepts an operation using the control unit's 5-bit ALUOP encoding and runs a 2-cycle registered multiply or a 32-iteration restoring divide. While it works it stalls the pipeline through BUSY, and it returns the result with a one-cycle DONE pulse. It implements full RISC-V M-extension semantics, including the divide-by-zero and signed-overflow cases.

## Interface
- XLEN, 32, operand/result width; only 32 supported.
- CLK  in  1  clock, rising edge.
- RESET  in  1  synchronous, active-high; highest priority.
- START  in  1  request; sampled only in IDLE.
- SELECT  in  5  ALUOP: 01011 MUL, 01100 MULH, 01101 MULHSU, 01110 MULHU, 01111 DIV, 10000 DIVU, 10001 REM, 10010 REMU.
- DATA1  in  32  rs1 operand / dividend.
- DATA2  in  32  rs2 operand / divisor.
- FLUSH  in  1  abort the in-flight operation.
- BUSY  out  1  pipeline stall; combinational.
- DONE  out  1  result-valid pulse, one cycle.
- RESULT  out  32  registered; holds its value until the next DONE.

## Operation
- States: IDLE, MUL, DIV, FIX, DONE.
- Accept: a request is accepted in IDLE when START=1, SELECT is in 01011..10010 and FLUSH=0. Opcode and operands are latched at acceptance.
- START with any other SELECT is ignored: the block stays in IDLE and BUSY=0.
- Multiply path: IDLE→MUL→DONE.
  - Operands are extended to 33 bits: sign-extended for MULH; DATA1 signed and DATA2 zero-extended for MULHSU; zero-extended otherwise.
  - The 66-bit product is registered in MUL.
  - MUL returns product[31:0]; MULH/MULHSU/MULHU return product[63:32].
- Divide path: IDLE→DIV (32 cycles)→FIX→DONE.
  - Signed ops take absolute values at acceptance and record qneg = sign1^sign2 and rneg = sign1.
  - Each DIV cycle performs one restoring step: {rem,quot} shifted left by 1; if rem ≥ divisor, subtract the divisor and set the quotient LSB. A 5-bit counter counts 0..31.
  - FIX negates the quotient if qneg and the remainder if rneg (signed ops only), then selects quotient or remainder.
- Special cases are detected at acceptance and go IDLE→DONE directly:
  - DATA2 = 0: DIV/DIVU return 0xFFFFFFFF; REM/REMU return DATA1.
  - DIV with 0x80000000 / 0xFFFFFFFF returns 0x80000000; REM with the same operands returns 0.
- DONE: DONE=1, RESULT valid. The next state is always IDLE. START is ignored in DONE.
- FLUSH: in any non-IDLE state the block goes to IDLE next cycle with no DONE and RESULT unchanged. In IDLE, FLUSH blocks acceptance.
- RESET: next state IDLE, RESULT=0, DONE=0, counter=0. It aborts mid-operation with the same effect.

## Timing
- Accept at cycle T.
- Multiply: DONE at T+2.
- Divide: DIV from T+1 to T+32, FIX at T+33, DONE at T+34.
- Special case: DONE at T+1.
- BUSY = (IDLE & START & valid op & !FLUSH) | state∈{MUL, DIV, FIX}.
- BUSY=0 in the DONE cycle, so the pipeline advances that cycle and captures RESULT.
- Reset values: BUSY=0, DONE=0, RESULT=0.
- Back-to-back: a new request can be accepted at DONE+1 at the earliest.

## Structure
- Package muldiv_pkg holds:
  - ALUOP localparams for the eight M codes, shared with the control unit and the ALU.
  - The state enum.
  - DIV_STEPS=32.
- Sub-module div_step: a combinational single restoring iteration. Inputs: rem, quot, divisor. Outputs: next rem and next quot.
- The top level holds the FSM, the operand and sign registers, the counter, the product register and the fix-up logic.

## Test plan
- MULH, DATA1=0xFFFFFFFF (-1), DATA2=0x00000002 → DONE at T+2, RESULT=0xFFFFFFFF. Also MUL 7×6=42 → RESULT=0x0000002A.
- DIV, DATA1=-7 (0xFFFFFFF9), DATA2=2 → DONE at T+34, RESULT=0xFFFFFFFD (-3). REM on the same operands → RESULT=0xFFFFFFFF (-1). BUSY high from T through T+33.
- DIVU with DATA2=0 → DONE at T+1, RESULT=0xFFFFFFFF. REM 0x80000000 by 0xFFFFFFFF → DONE at T+1, RESULT=0.
- DIVU 100/7 with FLUSH at T+10 → state IDLE at T+11, no DONE pulse, RESULT keeps its previous value, BUSY=0.
- RESET at T+5 during a DIV → IDLE, RESULT=0, DONE=0. START with SELECT=00001 → no accept, BUSY=0.
- START held high through DONE → exactly one accept per operation. The second accept happens at DONE+1 and its RESULT matches the reference model.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared RV32M definitions: ALUOP codes, sequencer states and divide length.
// Imported by the control unit, the ALU and the multiply/divide sequencer.
package muldiv_pkg;

    localparam int DIV_STEPS = 32;

    localparam logic [4:0] ALU_MUL    = 5'b01011;
    localparam logic [4:0] ALU_MULH   = 5'b01100;
    localparam logic [4:0] ALU_MULHSU = 5'b01101;
    localparam logic [4:0] ALU_MULHU  = 5'b01110;
    localparam logic [4:0] ALU_DIV    = 5'b01111;
    localparam logic [4:0] ALU_DIVU   = 5'b10000;
    localparam logic [4:0] ALU_REM    = 5'b10001;
    localparam logic [4:0] ALU_REMU   = 5'b10010;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_FIX,
        ST_DONE
    } state_t;

    function automatic logic is_mdop(input logic [4:0] op);
        return (op >= ALU_MUL) && (op <= ALU_REMU);
    endfunction

    function automatic logic is_divop(input logic [4:0] op);
        return (op >= ALU_DIV) && (op <= ALU_REMU);
    endfunction

    function automatic logic is_remop(input logic [4:0] op);
        return (op == ALU_REM) || (op == ALU_REMU);
    endfunction

endpackage

// File: rtl/muldiv_sequencer_div_step.sv
// One restoring-division iteration: shift {rem,quot} left and
// subtract the divisor when the partial remainder allows it.
module div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rem,
    input  logic [XLEN-1:0] quot,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] rem_next,
    output logic [XLEN-1:0] quot_next
);

    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;

    always_comb begin
        shifted = {rem, quot[XLEN-1]};
        diff    = shifted - {1'b0, divisor};
        if (shifted >= {1'b0, divisor}) begin
            rem_next  = diff[XLEN-1:0];
            quot_next = {quot[XLEN-2:0], 1'b1};
        end else begin
            rem_next  = shifted[XLEN-1:0];
            quot_next = {quot[XLEN-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// RV32M multi-cycle unit: 2-cycle multiply, 32-step restoring divide,
// with divide-by-zero and signed-overflow results resolved at acceptance.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            START,
    input  logic [4:0]      SELECT,
    input  logic [XLEN-1:0] DATA1,
    input  logic [XLEN-1:0] DATA2,
    input  logic            FLUSH,
    output logic            BUSY,
    output logic            DONE,
    output logic [XLEN-1:0] RESULT
);

    state_t state, state_next;

    logic [4:0]        op;
    logic [XLEN:0]     opa, opb;
    logic [XLEN-1:0]   rem, quot, divisor;
    logic [XLEN-1:0]   rem_n, quot_n;
    logic              qneg, rneg;
    logic [4:0]        cnt;

    logic              accept, sgn, zero, ovf, special;
    logic [XLEN-1:0]   special_val, abs1, abs2;
    logic [XLEN:0]     exta, extb;
    logic [2*XLEN-1:0] product;
    logic [XLEN-1:0]   mul_res, qfix, rfix, fix_val;

    assign accept = (state == ST_IDLE) && START && is_mdop(SELECT) && !FLUSH;
    assign sgn    = (SELECT == ALU_DIV) || (SELECT == ALU_REM);
    assign zero   = (DATA2 == '0);
    assign ovf    = sgn && (DATA1 == {1'b1, {(XLEN-1){1'b0}}}) && (&DATA2);
    assign special = is_divop(SELECT) && (zero || ovf);

    // Overflow only ever divides the most negative value, so DATA1 is the quotient.
    always_comb begin
        if (zero)
            special_val = is_remop(SELECT) ? DATA1 : '1;
        else
            special_val = is_remop(SELECT) ? '0 : DATA1;
    end

    assign abs1 = (sgn && DATA1[XLEN-1]) ? -DATA1 : DATA1;
    assign abs2 = (sgn && DATA2[XLEN-1]) ? -DATA2 : DATA2;

    always_comb begin
        exta = {1'b0, DATA1};
        extb = {1'b0, DATA2};
        unique case (1'b1)
            SELECT == ALU_MULH: begin
                exta = {DATA1[XLEN-1], DATA1};
                extb = {DATA2[XLEN-1], DATA2};
            end
            SELECT == ALU_MULHSU: exta = {DATA1[XLEN-1], DATA1};
            default: ;
        endcase
    end

    // Only the low 2*XLEN bits of the extended product are ever selected.
    assign product = {{(XLEN-1){opa[XLEN]}}, opa} * {{(XLEN-1){opb[XLEN]}}, opb};
    assign mul_res = (op == ALU_MUL) ? product[XLEN-1:0] : product[2*XLEN-1:XLEN];

    assign qfix    = qneg ? -quot : quot;
    assign rfix    = rneg ? -rem : rem;
    assign fix_val = is_remop(op) ? rfix : qfix;

    div_step #(.XLEN(XLEN)) u_div_step (
        .rem       (rem),
        .quot      (quot),
        .divisor   (divisor),
        .rem_next  (rem_n),
        .quot_next (quot_n)
    );

    always_ff @(posedge CLK) begin
        if (RESET)
            state <= ST_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (!is_divop(SELECT))
                        state_next = ST_MUL;
                    else if (special)
                        state_next = ST_DONE;
                    else
                        state_next = ST_DIV;
                end
            end
            ST_MUL:  state_next = ST_DONE;
            ST_DIV:  if (cnt == 5'(DIV_STEPS-1)) state_next = ST_FIX;
            ST_FIX:  state_next = ST_DONE;
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
        if (FLUSH && state != ST_IDLE)
            state_next = ST_IDLE;
    end

    always_comb begin
        BUSY = 1'b0;
        DONE = 1'b0;
        unique case (state)
            ST_IDLE: BUSY = accept;
            ST_MUL, ST_DIV, ST_FIX: BUSY = 1'b1;
            ST_DONE: DONE = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            RESULT <= '0;
            cnt    <= '0;
        end else begin
            unique case (state)
                ST_IDLE: if (accept) begin
                    op      <= SELECT;
                    opa     <= exta;
                    opb     <= extb;
                    rem     <= '0;
                    quot    <= abs1;
                    divisor <= abs2;
                    qneg    <= sgn && (DATA1[XLEN-1] ^ DATA2[XLEN-1]);
                    rneg    <= sgn && DATA1[XLEN-1];
                    cnt     <= '0;
                    if (special)
                        RESULT <= special_val;
                end
                ST_MUL: if (!FLUSH) RESULT <= mul_res;
                ST_DIV: begin
                    rem  <= rem_n;
                    quot <= quot_n;
                    cnt  <= cnt + 5'd1;
                end
                ST_FIX: if (!FLUSH) RESULT <= fix_val;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: directed RV32M vectors with
// hand-computed results and DONE cycle positions.
module tb_muldiv_sequencer;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        START = 1'b0;
    logic [4:0]  SELECT = 5'd0;
    logic [31:0] DATA1 = '0;
    logic [31:0] DATA2 = '0;
    logic        FLUSH = 1'b0;
    logic        BUSY, DONE;
    logic [31:0] RESULT;

    typedef struct {
        logic [31:0] res;
        int          at;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   done_cnt = 0;

    localparam logic [4:0] MUL = 5'b01011, MULH = 5'b01100, MULHSU = 5'b01101;
    localparam logic [4:0] MULHU = 5'b01110, DIV = 5'b01111, DIVU = 5'b10000;
    localparam logic [4:0] REM = 5'b10001, REMU = 5'b10010;

    muldiv_sequencer dut (
        .CLK    (CLK),
        .RESET  (RESET),
        .START  (START),
        .SELECT (SELECT),
        .DATA1  (DATA1),
        .DATA2  (DATA2),
        .FLUSH  (FLUSH),
        .BUSY   (BUSY),
        .DONE   (DONE),
        .RESULT (RESULT)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every DONE pulse must match the oldest pending expectation.
    always @(negedge CLK) begin
        if (DONE === 1'b1) begin
            done_cnt++;
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got result %h expected no DONE (cycle %0d)", RESULT, cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("result", RESULT, e.res);
                chk("done_cycle", 32'(cyc), 32'(e.at));
            end
        end
    end

    task automatic issue(input logic [4:0] sel, input logic [31:0] a, input logic [31:0] b,
                         input bit push, input logic [31:0] exp, input int lat);
        START  = 1'b1;
        SELECT = sel;
        DATA1  = a;
        DATA2  = b;
        if (push) q.push_back('{exp, cyc + lat});
        @(negedge CLK);
        START = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 100) begin
            @(negedge CLK);
            n++;
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
            q.delete();
        end
        @(negedge CLK);
    endtask

    initial begin
        int dc;
        repeat (3) @(negedge CLK);
        chk("reset_busy", {31'b0, BUSY}, 32'd0);
        chk("reset_done", {31'b0, DONE}, 32'd0);
        chk("reset_result", RESULT, 32'd0);
        RESET = 1'b0;
        @(negedge CLK);

        issue(MULH, 32'hFFFFFFFF, 32'h2, 1, 32'hFFFFFFFF, 2); drain();
        issue(MUL, 32'd7, 32'd6, 1, 32'h2A, 2); drain();
        issue(MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 32'hFFFFFFFE, 2); drain();
        issue(MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 32'hFFFFFFFF, 2); drain();

        // DIV -7/2 with BUSY tracked across the whole operation.
        START = 1'b1; SELECT = DIV; DATA1 = 32'hFFFFFFF9; DATA2 = 32'd2;
        q.push_back('{32'hFFFFFFFD, cyc + 34});
        #1 chk("busy_T", {31'b0, BUSY}, 32'd1);
        for (int k = 1; k <= 33; k++) begin
            @(negedge CLK);
            START = 1'b0;
            #1 chk("busy_div", {31'b0, BUSY}, 32'd1);
        end
        @(negedge CLK);
        #1 chk("busy_done", {31'b0, BUSY}, 32'd0);
        drain();

        issue(REM, 32'hFFFFFFF9, 32'd2, 1, 32'hFFFFFFFF, 34); drain();
        issue(DIV, 32'd7, 32'hFFFFFFFE, 1, 32'hFFFFFFFD, 34); drain();
        issue(REM, 32'd7, 32'hFFFFFFFE, 1, 32'd1, 34); drain();
        issue(DIVU, 32'd100, 32'd7, 1, 32'd14, 34); drain();
        issue(REMU, 32'd100, 32'd7, 1, 32'd2, 34); drain();

        issue(DIVU, 32'd1234, 32'd0, 1, 32'hFFFFFFFF, 1); drain();
        issue(REM, 32'h80000000, 32'hFFFFFFFF, 1, 32'd0, 1); drain();
        issue(DIV, 32'h80000000, 32'hFFFFFFFF, 1, 32'h80000000, 1); drain();
        issue(REMU, 32'd5, 32'd0, 1, 32'd5, 1); drain();

        // FLUSH mid-divide: no DONE, RESULT keeps the REMU value.
        dc = done_cnt;
        issue(DIVU, 32'd100, 32'd7, 0, 32'd0, 0);
        repeat (9) @(negedge CLK);
        FLUSH = 1'b1;
        @(negedge CLK);
        FLUSH = 1'b0;
        #1 chk("flush_busy", {31'b0, BUSY}, 32'd0);
        chk("flush_result", RESULT, 32'd5);
        repeat (40) @(negedge CLK);
        chk("flush_no_done", 32'(done_cnt), 32'(dc));

        // FLUSH in IDLE blocks acceptance.
        START = 1'b1; SELECT = MUL; FLUSH = 1'b1;
        #1 chk("idle_flush_busy", {31'b0, BUSY}, 32'd0);
        @(negedge CLK);
        START = 1'b0; FLUSH = 1'b0;
        repeat (4) @(negedge CLK);
        chk("idle_flush_no_done", 32'(done_cnt), 32'(dc));

        // RESET during a divide.
        issue(DIV, 32'hFFFFFFF9, 32'd2, 0, 32'd0, 0);
        repeat (4) @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);
        chk("rst_result", RESULT, 32'd0);
        chk("rst_done", {31'b0, DONE}, 32'd0);
        chk("rst_busy", {31'b0, BUSY}, 32'd0);
        RESET = 1'b0;
        repeat (40) @(negedge CLK);
        chk("rst_no_done", 32'(done_cnt), 32'(dc));

        // Unsupported ALUOP is ignored.
        START = 1'b1; SELECT = 5'b00001; DATA1 = 32'd3; DATA2 = 32'd4;
        #1 chk("bad_op_busy", {31'b0, BUSY}, 32'd0);
        repeat (3) @(negedge CLK);
        #1 chk("bad_op_busy_hold", {31'b0, BUSY}, 32'd0);
        START = 1'b0;
        @(negedge CLK);
        chk("bad_op_no_done", 32'(done_cnt), 32'(dc));

        // START held through DONE: second accept lands at DONE+1.
        START = 1'b1; SELECT = MUL; DATA1 = 32'd7; DATA2 = 32'd6;
        q.push_back('{32'h2A, cyc + 2});
        @(negedge CLK);
        @(negedge CLK);
        #1 chk("held_busy_done", {31'b0, BUSY}, 32'd0);
        @(negedge CLK);
        DATA1 = 32'h12345; DATA2 = 32'h100;
        q.push_back('{32'h01234500, cyc + 2});
        @(negedge CLK);
        START = 1'b0;
        drain();
        chk("held_done_count", 32'(done_cnt), 32'(dc + 2));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
